// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [3:0] state;
  logic       instr_en;
  logic       pc_en;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_wr;
  logic [1:0] alu_op;
  logic       branch;
  logic       mem_timeout;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
    input  opcode, mem_ready,
    output state, instr_en, pc_en, mem_rd, mem_wr, reg_wr, alu_op, branch,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  state, instr_en, pc_en, mem_rd, mem_wr, reg_wr, alu_op, branch,
`ifdef CTRL_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  mem_timeout
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with a bounded memory wait counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap unlisted opcodes in TRAP (else they act as NOPs).
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
`else
    S_JAL    = 4'd10
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       w_wait_state;
  logic       w_limit;
  logic       w_timeout;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_limit      = (r_wait_cnt == WAIT_LIM);
  // mem_ready on the limit cycle wins over the abort
  assign w_timeout    = w_wait_state && !bus.mem_ready && w_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
    end else begin
      if (w_wait_state && !bus.mem_ready && !w_limit)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;

      case (r_state)
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
                  else if (w_timeout) r_state <= S_FETCH;
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:           r_state <= S_TRAP;
`else
            default:           r_state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR: r_state <= (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
                  else if (w_timeout) r_state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready || w_timeout) r_state <= S_FETCH;
        S_EXECR:  r_state <= S_ALUWB;
        S_EXECI:  r_state <= S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP:   r_state <= S_TRAP;
`endif
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.state       = r_state;
    bus.instr_en    = 1'b0;
    bus.pc_en       = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.reg_wr      = 1'b0;
    bus.alu_op      = 2'b00;
    bus.branch      = 1'b0;
    bus.mem_timeout = w_timeout;
    case (r_state)
      S_FETCH: begin
        bus.mem_rd   = 1'b1;
        bus.instr_en = bus.mem_ready;
        bus.pc_en    = bus.mem_ready;
      end
      S_MEMRD:  bus.mem_rd = 1'b1;
      S_MEMWR:  bus.mem_wr = 1'b1;
      S_MEMWB:  bus.reg_wr = 1'b1;
      S_EXECR:  bus.alu_op = 2'b10;
      S_EXECI:  bus.alu_op = 2'b10;
      S_ALUWB:  bus.reg_wr = 1'b1;
      S_BRANCH: begin
        bus.alu_op = 2'b01;
        bus.branch = 1'b1;
      end
      S_JAL: begin
        bus.pc_en  = 1'b1;
        bus.reg_wr = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized traffic against
// an instruction-level reference model of the controller.
module tb_multicycle_ctrl;
  localparam int MW = 4;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int m_state;
  int m_cnt;
  logic [3:0] o_st;
  logic [9:0] o_vec;
  logic       w_ill;
  logic [9:0] dut_vec;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign w_ill = bus.illegal;
`else
  assign w_ill = 1'b0;
`endif
  // {instr_en, pc_en, mem_rd, mem_wr, reg_wr, alu_op, branch, mem_timeout, illegal}
  assign dut_vec = {bus.instr_en, bus.pc_en, bus.mem_rd, bus.mem_wr, bus.reg_wr,
                    bus.alu_op, bus.branch, bus.mem_timeout, w_ill};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_wait(int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic [9:0] model_out(int s, bit rdy, int cnt);
    bit ie, pe, rd, wr, rw, br, to, il;
    logic [1:0] alu;
    ie  = (s == 0) && rdy;
    pe  = ie || (s == 10);
    rd  = (s == 0) || (s == 3);
    wr  = (s == 5);
    rw  = (s == 4) || (s == 8) || (s == 10);
    alu = (s == 6 || s == 7) ? 2'b10 : (s == 9) ? 2'b01 : 2'b00;
    br  = (s == 9);
    to  = is_wait(s) && !rdy && (cnt == MW);
    il  = (s == 11);
    return {ie, pe, rd, wr, rw, alu, br, to, il};
  endfunction

  function automatic int decode_next(logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011: return 2;
      7'b0110011:             return 6;
      7'b0010011:             return 7;
      7'b1100011:             return 9;
      7'b1101111:             return 10;
`ifdef CTRL_ILLEGAL_TRAP_EN
      default:                return 11;
`else
      default:                return 0;
`endif
    endcase
  endfunction

  function automatic void model_step(bit r, bit rdy, logic [6:0] op);
    if (r) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (is_wait(m_state)) begin
      if (rdy) begin
        m_state = (m_state == 0) ? 1 : (m_state == 3) ? 4 : 0;
        m_cnt   = 0;
      end else if (m_cnt == MW) begin
        m_state = 0;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      case (m_state)
        1:       m_state = decode_next(op);
        2:       m_state = (op == LD) ? 3 : 5;
        6, 7:    m_state = 8;
        11:      m_state = 11;
        default: m_state = 0;
      endcase
    end
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cyc(input bit r, input bit rdy, input logic [6:0] op);
    rst           = r;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    @(negedge clk);
    o_st  = bus.state;
    o_vec = dut_vec;
    check("state", {28'd0, o_st}, m_state);
    check("ctrl", {22'd0, o_vec}, {22'd0, model_out(m_state, rdy, m_cnt)});
    @(posedge clk);
    model_step(r, rdy, op);
    #1;
  endtask

  logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                          7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    logic [31:0] seq;
    logic [6:0]  tos;
    int          cnt_a, cnt_b;
    bit          mode, rdy, r;
    logic [6:0]  op;
    int          trap_cyc;

    rst = 1'b1; bus.mem_ready = 1'b0; bus.opcode = 7'd0;
    m_state = 0; m_cnt = 0;
    @(posedge clk); #1;

    // Reset state
    cyc(1, 0, 7'd0);
    check("rst_state", {28'd0, o_st}, 32'd0);
    check("rst_memrd", {31'd0, o_vec[7]}, 32'd1);

    // Load, no waits
    seq = 0; cnt_a = 0;
    cyc(1, 0, LD);
    cyc(0, 1, LD); seq = {seq[27:0], o_st}; cnt_a += int'(o_vec[5]);
    for (int i = 0; i < 4; i++) begin
      cyc(0, i == 2, LD); seq = {seq[27:0], o_st}; cnt_a += int'(o_vec[5]);
      if (o_st == 4'd4) check("load_rw_s4", {31'd0, o_vec[5]}, 32'd1);
    end
    cyc(0, 0, LD); seq = {seq[27:0], o_st};
    check("load_seq", seq, 32'h0001_2340);
    check("load_rw_cnt", cnt_a, 32'd1);

    // Store with 3 wait cycles
    seq = 0; cnt_a = 0; cnt_b = 0;
    cyc(1, 0, ST);
    for (int i = 0; i < 8; i++) begin
      cyc(0, (i == 0) || (i == 6), ST);
      seq = {seq[27:0], o_st};
      cnt_a += int'(o_vec[6]);
      cnt_b += int'(o_vec[5]);
    end
    check("store_seq", seq, 32'h0125_5550);
    check("store_wr_cnt", cnt_a, 32'd4);
    check("store_rw_cnt", cnt_b, 32'd0);

    // Fetch timeout
    tos = 0; cnt_a = 0; seq = 0;
    cyc(1, 0, LD);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, LD);
      tos = {tos[5:0], o_vec[1]};
      cnt_a += int'(o_vec[9]);
      seq = {seq[27:0], o_st};
    end
    check("to_pulse", {25'd0, tos}, 32'b0000100);
    check("to_instr", cnt_a, 32'd0);
    check("to_states", seq, 32'd0);

    // mem_ready exactly on the limit cycle in MEMRD
    cyc(1, 0, LD);
    cyc(0, 1, LD); cyc(0, 0, LD); cyc(0, 0, LD);
    for (int i = 0; i < MW; i++) cyc(0, 0, LD);
    cyc(0, 1, LD);
    check("bnd_state", {28'd0, o_st}, 32'd3);
    check("bnd_to", {31'd0, o_vec[1]}, 32'd0);
    cyc(0, 0, LD);
    check("bnd_next", {28'd0, o_st}, 32'd4);

    // Illegal opcode
    cyc(1, 0, BAD);
    cyc(0, 1, BAD); cyc(0, 0, BAD);
    check("ill_decode", {28'd0, o_st}, 32'd1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, i[0], BAD);
      if (o_st == 4'd11 && o_vec[0] && o_vec[9:2] == 8'd0) cnt_a++;
    end
    check("ill_hold", cnt_a, 32'd10);
    cyc(1, 0, BAD);
    cyc(0, 0, BAD);
    check("ill_rst", {28'd0, o_st}, 32'd0);
    check("ill_flag", {31'd0, o_vec[0]}, 32'd0);
`else
    cyc(0, 0, BAD);
    check("ill_nop", {28'd0, o_st}, 32'd0);
`endif

    // Reset during MEMRD wait with counter at 3
    cyc(1, 0, LD);
    cyc(0, 1, LD); cyc(0, 0, LD); cyc(0, 0, LD);
    for (int i = 0; i < 3; i++) cyc(0, 0, LD);
    cyc(1, 0, LD);
    check("rmw_to", {31'd0, o_vec[1]}, 32'd0);
    tos = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, LD);
      if (i == 0) check("rmw_state", {28'd0, o_st}, 32'd0);
      tos = {tos[5:0], o_vec[1]};
    end
    check("rmw_cnt0", {25'd0, tos}, 32'b0000001);

    // Randomized traffic
    cyc(1, 0, LD);
    mode = 1'b1; trap_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rdy = mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      op  = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 7'($urandom);
      trap_cyc = (m_state == 11) ? trap_cyc + 1 : 0;
      r = ($urandom_range(0, 299) == 0) || (trap_cyc > 5);
      cyc(r, rdy, op);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
